// File: rtl/gpio_input_conditioner.sv
// Raw pin conditioning for one GPIO input bank: synchronize, debounce,
// detect edges and keep a firmware-cleared sticky rise flag per channel.
module gpio_input_conditioner #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] gpio_i_raw,
    input  logic [WIDTH-1:0] gpio_i_evt_clr,
    output logic [WIDTH-1:0] gpio_o_level,
    output logic [WIDTH-1:0] gpio_o_rise,
    output logic [WIDTH-1:0] gpio_o_fall,
    output logic [WIDTH-1:0] gpio_o_evt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] syn;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= gpio_i_raw;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign syn = sync_q[SYNC_STAGES-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        logic [CW-1:0] cnt;
        logic          lvl_q;
        logic          rise_q;
        logic          fall_q;
        logic          evt_q;

        // Any sample matching the current level restarts the stability count.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt    <= '0;
                lvl_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (syn[i] == lvl_q) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    cnt    <= '0;
                    lvl_q  <= syn[i];
                    rise_q <= syn[i];
                    fall_q <= ~syn[i];
                end else if (cnt != CNT_SAT) begin
                    cnt <= cnt + CW'(1);
                end
            end
        end

        // A rise seen in the same cycle as a clear keeps the flag set.
        always_ff @(posedge clk) begin
            if (rst) begin
                evt_q <= 1'b0;
            end else if (rise_q) begin
                evt_q <= 1'b1;
            end else if (gpio_i_evt_clr[i]) begin
                evt_q <= 1'b0;
            end
        end

        assign gpio_o_level[i] = lvl_q;
        assign gpio_o_rise[i]  = rise_q;
        assign gpio_o_fall[i]  = fall_q;
        assign gpio_o_evt[i]   = evt_q;
    end

endmodule
